// File: rtl/weight_rx_buffer_pkg.sv
// weight_rx_buffer_pkg
//   Shared constants and types for the weight receive buffer:
//   - COEFF_WIDTH  : global coefficient width
//   - KERN_S_*     : per-layer kernel sizes (coefficients per load)
//   - rx_state_e   : receive FSM states (IDLE / LOAD / READY)
//   - kern_aw()    : address width needed to index a kernel
package weight_rx_buffer_pkg;

  localparam int unsigned COEFF_WIDTH  = 16;

  localparam int unsigned KERN_S_CONV1 = 150;
  localparam int unsigned KERN_S_CONV2 = 2400;
  localparam int unsigned KERN_S_FC1   = 400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } rx_state_e;

  // Address width for a kernel of n coefficients; never below one bit.
  function automatic int unsigned kern_aw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_rx_ram.sv
// weight_rx_ram
//   Simple dual-port synchronous RAM: one write port, one registered
//   read-first read port. Contents are not reset; only the read register is.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset (read reg only)
//     we, waddr, wdata    : write port
//     re, raddr, rdata    : read port, rdata valid the cycle after re, holds
//                           while re=0; out-of-range addresses return zero
module weight_rx_ram
  import weight_rx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = KERN_S_CONV1,
  parameter int unsigned WIDTH = COEFF_WIDTH,
  parameter int unsigned AW    = kern_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_in_range;
  logic             rd_in_range;

  // Addresses past DEPTH are legal on the port but touch no storage.
  assign wr_in_range = (32'(waddr) < DEPTH);
  assign rd_in_range = (32'(raddr) < DEPTH);

  // Write port.
  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; non-blocking update gives read-first on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_in_range ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/weight_rx_buffer.sv
// weight_rx_buffer
//   Receives exactly KERN_S coefficients from an ap_fifo-style stream into a
//   local RAM, then serves them to a conv PE through an ap_memory-style read
//   port with one-cycle latency.
//   Build option: WEIGHT_RX_PINGPONG_EN
//     undefined : single bank; weight_valid drops when a reload starts
//     defined   : two banks; loads fill the shadow bank and the banks swap on
//                 completion, so weight_valid stays high across reloads
//   Ports:
//     ap_clk, ap_rst_n            : clock, asynchronous active-low reset
//     ap_start, ap_idle, ap_done  : block-level handshake
//     input_V_dout/empty_n/read   : FIFO head data, non-empty flag, pop strobe
//     weight_valid                : active bank holds a complete kernel
//     rd_address0, rd_ce0, rd_q0  : PE read port (registered data)
module weight_rx_buffer
  import weight_rx_buffer_pkg::*;
#(
  parameter int unsigned KERN_S     = KERN_S_CONV1,
  parameter int unsigned DATA_WIDTH = COEFF_WIDTH,
  parameter int unsigned AW         = $clog2(KERN_S)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  output logic                  weight_valid,
  input  logic [AW-1:0]         rd_address0,
  input  logic                  rd_ce0,
  output logic [DATA_WIDTH-1:0] rd_q0
);

  localparam logic [AW-1:0] LAST_IDX = AW'(KERN_S - 1);

  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] wr_cnt_nxt;
  logic          ap_idle_nxt;
  logic          ap_done_nxt;
  logic          weight_valid_nxt;
  logic          wr_en;

`ifdef WEIGHT_RX_PINGPONG_EN
  logic          bank;      // active (PE-facing) bank; the other is the shadow
  logic          bank_nxt;
`endif

  // Pop and write together: the FIFO head is consumed on the same edge.
  assign wr_en        = (state == LOAD) && input_V_empty_n;
  assign input_V_read = wr_en;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt        = state;
    wr_cnt_nxt       = wr_cnt;
    ap_done_nxt      = 1'b0;
    weight_valid_nxt = weight_valid;
`ifdef WEIGHT_RX_PINGPONG_EN
    bank_nxt         = bank;
`endif

    unique case (state)
      IDLE: begin
        if (ap_start) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
        end
      end

      // ap_start is ignored here; only FIFO availability advances the load.
      LOAD: begin
        if (wr_en) begin
          if (wr_cnt == LAST_IDX) begin
            state_nxt        = READY;
            wr_cnt_nxt       = '0;
            ap_done_nxt      = 1'b1;
            weight_valid_nxt = 1'b1;
`ifdef WEIGHT_RX_PINGPONG_EN
            bank_nxt         = ~bank;
`endif
          end else begin
            wr_cnt_nxt = wr_cnt + AW'(1);
          end
        end
      end

      READY: begin
        if (ap_start) begin
          state_nxt  = LOAD;
          wr_cnt_nxt = '0;
`ifndef WEIGHT_RX_PINGPONG_EN
          // Single bank is about to be overwritten.
          weight_valid_nxt = 1'b0;
`endif
        end
      end

      default: begin
        state_nxt  = IDLE;
        wr_cnt_nxt = '0;
      end
    endcase

    ap_idle_nxt = (state_nxt == IDLE);
  end

  // State and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      ap_idle      <= 1'b1;
      ap_done      <= 1'b0;
      weight_valid <= 1'b0;
`ifdef WEIGHT_RX_PINGPONG_EN
      bank         <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      wr_cnt       <= wr_cnt_nxt;
      ap_idle      <= ap_idle_nxt;
      ap_done      <= ap_done_nxt;
      weight_valid <= weight_valid_nxt;
`ifdef WEIGHT_RX_PINGPONG_EN
      bank         <= bank_nxt;
`endif
    end
  end

`ifdef WEIGHT_RX_PINGPONG_EN
  logic [DATA_WIDTH-1:0] q_bank0;
  logic [DATA_WIDTH-1:0] q_bank1;
  logic                  rd_sel;

  // Bank 0 is written while bank 1 is active, and vice versa.
  weight_rx_ram #(
    .DEPTH (KERN_S),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_ram_bank0 (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .we    (wr_en & bank),
    .waddr (wr_cnt),
    .wdata (input_V_dout),
    .re    (rd_ce0 & ~bank),
    .raddr (rd_address0),
    .rdata (q_bank0)
  );

  weight_rx_ram #(
    .DEPTH (KERN_S),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_ram_bank1 (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .we    (wr_en & ~bank),
    .waddr (wr_cnt),
    .wdata (input_V_dout),
    .re    (rd_ce0 & bank),
    .raddr (rd_address0),
    .rdata (q_bank1)
  );

  // Remember which bank served the last read so rd_q0 holds while rd_ce0=0,
  // and a read issued in the swap cycle still comes from the old bank.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_sel <= 1'b0;
    end else if (rd_ce0) begin
      rd_sel <= bank;
    end
  end

  assign rd_q0 = rd_sel ? q_bank1 : q_bank0;
`else
  weight_rx_ram #(
    .DEPTH (KERN_S),
    .WIDTH (DATA_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (input_V_dout),
    .re    (rd_ce0),
    .raddr (rd_address0),
    .rdata (rd_q0)
  );
`endif

endmodule

// File: tb/tb_weight_rx_buffer.sv
// tb_weight_rx_buffer
//   Self-checking bench for weight_rx_buffer with KERN_S=8. A queue models the
//   FIFO; a kernel-level model tracks which coefficients form the active
//   kernel, when the load must complete and what every read must return.
//   Honours WEIGHT_RX_PINGPONG_EN for the reload expectations.
module tb_weight_rx_buffer;

  localparam int KS = 8;
  localparam int DW = 16;
  localparam int AW = 3;
`ifdef WEIGHT_RX_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_idle;
  logic          ap_done;
  logic [DW-1:0] input_V_dout;
  logic          input_V_empty_n;
  logic          input_V_read;
  logic          weight_valid;
  logic [AW-1:0] rd_address0;
  logic          rd_ce0;
  logic [DW-1:0] rd_q0;

  weight_rx_buffer #(.KERN_S(KS), .DATA_WIDTH(DW)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_idle         (ap_idle),
    .ap_done         (ap_done),
    .input_V_dout    (input_V_dout),
    .input_V_empty_n (input_V_empty_n),
    .input_V_read    (input_V_read),
    .weight_valid    (weight_valid),
    .rd_address0     (rd_address0),
    .rd_ce0          (rd_ce0),
    .rd_q0           (rd_q0)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // FIFO model and kernel-level reference state.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] vals[KS];
  bit            gate;
  bit            model_loading, model_wv, model_idle, q_known;
  int            mcnt;
  logic [DW-1:0] shadow[KS];
  logic [DW-1:0] active[KS];
  logic [DW-1:0] exp_q;

  int cyc, pops, first_pop_cyc, last_pop_cyc, done_cnt, done_cyc;
  int bad_pop, done_err, wv_err, idle_err, rd_err;

  task automatic clear_tallies();
    pops = 0; done_cnt = 0; done_cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0;
    bad_pop = 0; done_err = 0; wv_err = 0; idle_err = 0; rd_err = 0;
  endtask

  task automatic reset_model();
    model_loading = 0; mcnt = 0; model_wv = 0; model_idle = 1;
    q_known = 1; exp_q = '0;
  endtask

  // One clock cycle: drive FIFO head, score the cycle against the model.
  // Called at posedge+1, returns at the next posedge+1.
  task automatic tick();
    bit            start_seen, complete, did_pop;
    logic [DW-1:0] tmp;
    input_V_empty_n = gate && (fifo_q.size() != 0);
    input_V_dout    = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    #2;
    start_seen = ap_start && !model_loading;
    complete   = 0;
    did_pop    = input_V_read;
    if (input_V_read) begin
      if (pops == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pops++;
      if (!input_V_empty_n || !model_loading) bad_pop++;
    end
    if (model_loading) begin
      if (input_V_read !== input_V_empty_n) bad_pop++;
      if (input_V_empty_n) begin
        if (mcnt < KS) shadow[mcnt] = input_V_dout;
        mcnt++;
        if (mcnt == KS) complete = 1;
      end
    end
    if (rd_ce0) begin
      q_known = model_wv;
      if (model_wv) exp_q = active[rd_address0];
    end
    @(posedge ap_clk); #1;
    cyc++;
    if (did_pop && fifo_q.size() != 0) tmp = fifo_q.pop_front();
    if (complete) begin
      active = shadow; model_wv = 1; model_loading = 0;
    end
    if (start_seen) begin
      model_loading = 1; mcnt = 0; model_idle = 0;
      if (!PP) model_wv = 0;
    end
    if (ap_done) begin done_cnt++; done_cyc = cyc; end
    if (ap_done !== complete) done_err++;
    if (weight_valid !== model_wv) wv_err++;
    if (ap_idle !== model_idle) idle_err++;
    if (q_known && rd_q0 !== exp_q) rd_err++;
  endtask

  task automatic test_reset();
    ap_rst_n = 0; ap_start = 0; rd_ce0 = 0; rd_address0 = '0;
    input_V_dout = 16'h1234; input_V_empty_n = 1; gate = 0; cyc = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", ap_idle); end
    checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", ap_done); end
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", input_V_read); end
    checks++; if (weight_valid !== 1'b0) begin errors++; $display("FAIL rst_wv: got %b expected 0", weight_valid); end
    checks++; if (rd_q0 !== '0) begin errors++; $display("FAIL rst_q: got %0h expected 0", rd_q0); end
    #2 ap_rst_n = 1;
    @(posedge ap_clk); #1;
    reset_model();
  endtask

  task automatic test_continuous_load();
    clear_tallies();
    fifo_q.delete();
    for (int i = 0; i < KS; i++) fifo_q.push_back(DW'(i + 1));
    gate = 1; rd_ce0 = 0;
    ap_start = 1; tick(); ap_start = 0;
    for (int i = 0; i < 4 * KS && done_cnt == 0; i++) tick();
    repeat (3) tick();
    checks++; if (pops != KS) begin errors++; $display("FAIL cont_pops: got %0d expected %0d", pops, KS); end
    checks++; if (last_pop_cyc - first_pop_cyc != KS - 1) begin errors++; $display("FAIL cont_consecutive: got span %0d expected %0d", last_pop_cyc - first_pop_cyc, KS - 1); end
    checks++; if (done_cyc - first_pop_cyc != KS) begin errors++; $display("FAIL cont_done_latency: got %0d expected %0d", done_cyc - first_pop_cyc, KS); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cont_done_count: got %0d expected 1", done_cnt); end
    checks++; if (weight_valid !== 1'b1) begin errors++; $display("FAIL cont_wv: got %b expected 1", weight_valid); end
    checks++; if (bad_pop + done_err + wv_err + idle_err != 0) begin errors++; $display("FAIL cont_protocol: got pop %0d done %0d wv %0d idle %0d errors expected 0", bad_pop, done_err, wv_err, idle_err); end
    for (int i = 0; i < KS; i++) begin
      rd_ce0 = 1; rd_address0 = AW'(i); tick();
      checks++; if (rd_q0 !== DW'(i + 1)) begin errors++; $display("FAIL cont_read[%0d]: got %0d expected %0d", i, rd_q0, i + 1); end
    end
    rd_ce0 = 0;
  endtask

  task automatic test_read_hold();
    logic [DW-1:0] held;
    clear_tallies();
    rd_ce0 = 1; rd_address0 = AW'(2); tick();
    held = active[2];
    rd_ce0 = 0;
    for (int i = 0; i < 6; i++) begin
      rd_address0 = AW'($urandom);
      tick();
      checks++; if (rd_q0 !== held) begin errors++; $display("FAIL hold[%0d]: got %0d expected %0d", i, rd_q0, held); end
    end
  endtask

  task automatic test_reload();
    clear_tallies();
    fifo_q.delete();
    for (int i = 0; i < KS; i++) fifo_q.push_back(DW'(i + 11));
    gate = 1;
    rd_ce0 = 1; rd_address0 = AW'($urandom);
    ap_start = 1; tick(); ap_start = 0;
    checks++; if (weight_valid !== PP) begin errors++; $display("FAIL reload_wv_after_start: got %b expected %b", weight_valid, PP); end
    for (int i = 0; i < 4 * KS && done_cnt == 0; i++) begin
      rd_address0 = AW'($urandom); tick();
    end
    repeat (2) begin rd_address0 = AW'($urandom); tick(); end
    checks++; if (pops != KS) begin errors++; $display("FAIL reload_pops: got %0d expected %0d", pops, KS); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL reload_done_count: got %0d expected 1", done_cnt); end
    checks++; if (rd_err != 0) begin errors++; $display("FAIL reload_reads: got %0d bad reads expected 0", rd_err); end
    checks++; if (bad_pop + done_err + wv_err + idle_err != 0) begin errors++; $display("FAIL reload_protocol: got pop %0d done %0d wv %0d idle %0d errors expected 0", bad_pop, done_err, wv_err, idle_err); end
    for (int i = 0; i < KS; i++) begin
      rd_address0 = AW'(i); tick();
      checks++; if (rd_q0 !== DW'(i + 11)) begin errors++; $display("FAIL reload_read[%0d]: got %0d expected %0d", i, rd_q0, i + 11); end
    end
    rd_ce0 = 0;
  endtask

  task automatic test_stalled_fifo();
    clear_tallies();
    fifo_q.delete();
    for (int i = 0; i < KS; i++) begin vals[i] = DW'($urandom); fifo_q.push_back(vals[i]); end
    gate = 0; rd_ce0 = 0;
    ap_start = 1; tick(); ap_start = 0;
    for (int k = 0; k < 6 * KS && done_cnt == 0; k++) begin
      gate = (k % 3 == 0); tick();
    end
    gate = 1; repeat (2) tick();
    checks++; if (pops != KS) begin errors++; $display("FAIL stall_pops: got %0d expected %0d", pops, KS); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL stall_strobe: got %0d bad strobes expected 0", bad_pop); end
    checks++; if (done_cyc != last_pop_cyc + 1 || done_cnt != 1) begin errors++; $display("FAIL stall_done: got cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, last_pop_cyc + 1); end
    checks++; if (done_err + wv_err + idle_err != 0) begin errors++; $display("FAIL stall_protocol: got done %0d wv %0d idle %0d errors expected 0", done_err, wv_err, idle_err); end
    for (int i = 0; i < KS; i++) begin
      rd_ce0 = 1; rd_address0 = AW'(i); tick();
      checks++; if (rd_q0 !== vals[i]) begin errors++; $display("FAIL stall_read[%0d]: got %0h expected %0h", i, rd_q0, vals[i]); end
    end
    rd_ce0 = 0;
  endtask

  task automatic test_start_during_load();
    clear_tallies();
    fifo_q.delete();
    for (int i = 0; i < 2 * KS; i++) fifo_q.push_back(DW'($urandom));
    gate = 1;
    ap_start = 1; tick(); ap_start = 0;
    for (int i = 0; i < 8 * KS && mcnt < 4; i++) begin
      gate = ($urandom_range(0, 3) != 0); rd_ce0 = $urandom_range(0, 1); rd_address0 = AW'($urandom); tick();
    end
    ap_start = 1; gate = 1; tick(); ap_start = 0;
    for (int i = 0; i < 8 * KS && done_cnt == 0; i++) begin
      gate = ($urandom_range(0, 3) != 0); rd_ce0 = $urandom_range(0, 1); rd_address0 = AW'($urandom); tick();
    end
    gate = 1; repeat (4) tick();
    checks++; if (pops != KS) begin errors++; $display("FAIL sdl_pops: got %0d expected %0d", pops, KS); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL sdl_done_count: got %0d expected 1", done_cnt); end
    checks++; if (bad_pop + done_err + wv_err + idle_err + rd_err != 0) begin errors++; $display("FAIL sdl_protocol: got pop %0d done %0d wv %0d idle %0d rd %0d errors expected 0", bad_pop, done_err, wv_err, idle_err, rd_err); end
    rd_ce0 = 0;
  endtask

  task automatic test_reset_mid_load();
    clear_tallies();
    fifo_q.delete();
    for (int i = 0; i < KS; i++) fifo_q.push_back(DW'($urandom));
    gate = 1;
    ap_start = 1; tick(); ap_start = 0;
    for (int i = 0; i < 4 * KS && mcnt < 3; i++) tick();
    checks++; if (pops != 3) begin errors++; $display("FAIL rml_pre_pops: got %0d expected 3", pops); end
    input_V_empty_n = 1;
    #2 ap_rst_n = 0;
    #1;
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rml_idle: got %b expected 1", ap_idle); end
    checks++; if (input_V_read !== 1'b0) begin errors++; $display("FAIL rml_read: got %b expected 0", input_V_read); end
    checks++; if (weight_valid !== 1'b0) begin errors++; $display("FAIL rml_wv: got %b expected 0", weight_valid); end
    checks++; if (rd_q0 !== '0) begin errors++; $display("FAIL rml_q: got %0h expected 0", rd_q0); end
    @(posedge ap_clk); #1;
    checks++; if (input_V_read !== 1'b0 || ap_done !== 1'b0) begin errors++; $display("FAIL rml_in_reset: got read %b done %b expected 0 0", input_V_read, ap_done); end
    #2 ap_rst_n = 1;
    @(posedge ap_clk); #1;
    reset_model();
    clear_tallies();
    fifo_q.delete();
    for (int i = 0; i < KS; i++) begin vals[i] = DW'($urandom); fifo_q.push_back(vals[i]); end
    fifo_q.push_back(DW'($urandom));
    ap_start = 1; tick(); ap_start = 0;
    for (int i = 0; i < 4 * KS && done_cnt == 0; i++) tick();
    repeat (3) tick();
    checks++; if (pops != KS) begin errors++; $display("FAIL rml_pops: got %0d expected %0d", pops, KS); end
    checks++; if (bad_pop + done_err + wv_err + idle_err != 0) begin errors++; $display("FAIL rml_protocol: got pop %0d done %0d wv %0d idle %0d errors expected 0", bad_pop, done_err, wv_err, idle_err); end
    for (int i = 0; i < KS; i++) begin
      rd_ce0 = 1; rd_address0 = AW'(i); tick();
      checks++; if (rd_q0 !== vals[i]) begin errors++; $display("FAIL rml_read[%0d]: got %0h expected %0h", i, rd_q0, vals[i]); end
    end
    rd_ce0 = 0;
  endtask

  initial begin
    test_reset();
    test_continuous_load();
    test_read_hold();
    test_reload();
    test_stalled_fifo();
    test_start_during_load();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_rx_buffer.md
Name: weight_rx_buffer

Overview:
Receiving end of the coefficient stream driven by the weight streamers. Pops exactly KERN_S coefficients from an ap_fifo-style input and writes them into a local synchronous RAM. Once the load completes, it serves them to a conv PE through an ap_memory-style read port with one-cycle latency. Sits between the weight FIFO and the convolution datapath.

Parameters:
KERN_S, 150, number of coefficients per load (set from the per-layer kernel size constant)
DATA_WIDTH, 16, coefficient width (set from the global coeff_width constant)
AW, $clog2(KERN_S), address width (derived; not overridden)

Ports:
ap_clk  in  1  clock, all logic on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  single-cycle pulse; starts a load
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse on the cycle the last coefficient is written
input_V_dout  in  DATA_WIDTH  FIFO head data, valid while empty_n=1
input_V_empty_n  in  1  FIFO non-empty
input_V_read  out  1  pop strobe; data is consumed in the same cycle
weight_valid  out  1  active bank holds a complete, coherent kernel
rd_address0  in  AW  PE read address
rd_ce0  in  1  PE read enable
rd_q0  out  DATA_WIDTH  read data, registered

Behaviour:
- Interface: one clock (ap_clk). Reset ap_rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE; ap_idle=1; ap_done=0; input_V_read=0; weight_valid=0; rd_q0=0.
  - Write counter and bank select = 0.
  - RAM contents are not reset.
- FSM states: IDLE, LOAD, READY.
  - IDLE: ap_start -> LOAD, counter=0.
  - LOAD: input_V_read = input_V_empty_n, combinational.
    - Each cycle with read=1: RAM[counter] <= input_V_dout and counter increments.
    - When a write occurs at counter==KERN_S-1: ap_done=1 next cycle, weight_valid=1, counter=0, state -> READY.
    - empty_n=0 stalls with no write and no counter change. No timeout.
  - READY: ap_start -> LOAD.
    - Single-bank build: weight_valid drops to 0 the cycle after ap_start is sampled.
- Throughput: 1 coefficient/cycle. A full load takes KERN_S cycles when the FIFO never empties.
- ap_start during LOAD is ignored. Restart is not allowed.
- Read port:
  - rd_ce0=1 at cycle t -> rd_q0 = RAM[rd_address0] at t+1.
  - rd_ce0=0: rd_q0 holds its last value.
  - Reads while weight_valid=0 return unspecified data but must not disturb the load.
- Out-of-range rd_address0 (>= KERN_S): returns unspecified data, with no side effects.
- Simultaneous read and write to the same address: the read returns the old data (read-first).
- Reset mid-LOAD: returns to IDLE immediately; the partial kernel is discarded. No pop occurs while ap_rst_n=0.

Optional Feature:
WEIGHT_RX_PINGPONG_EN
- Defined:
  - Two RAM banks. LOAD writes the shadow bank; PE reads always come from the active bank.
  - On load completion the banks swap in the same cycle that weight_valid would rise.
  - weight_valid stays 1 across reloads after the first complete load. The PE never sees a partial kernel.
  - A read issued in the swap cycle returns data from the old bank.
- Undefined: single bank; behaviour exactly as described above.

Decomposition:
- Shared package/header:
  - coeff_width and the kern_s_* per-layer constants, in the existing layer-size header.
  - FSM state enum (IDLE/LOAD/READY), in the common types header.
- One sub-module: weight_rx_ram, a simple dual-port synchronous RAM (1 write port, 1 read-first registered read port), parameterised by depth and width.
- In ping-pong mode the top level instantiates weight_rx_ram twice.

Test Plan:
- Continuous load: KERN_S=8, FIFO always non-empty with values 1..8; ap_start pulse.
  - Exactly 8 read strobes on consecutive cycles.
  - ap_done pulses once, 8 cycles after the first read.
  - Then weight_valid=1, and reading addr 0..7 gives 1..8 with one-cycle latency.
- Stalled FIFO: empty_n toggles 1,0,0,1,...
  - input_V_read asserts only when empty_n=1.
  - Final RAM contents are still 1..8. ap_done fires only after the 8th pop.
- Reset mid-load: ap_rst_n low after 3 pops.
  - Outputs reach reset values asynchronously.
  - After a new ap_start, exactly 8 further pops occur and the new data is stored from addr 0.
- ap_start during LOAD: pulse while counter=4.
  - No restart; the load completes after exactly 8 pops total.
- Reload:
  - Single bank: ap_start in READY drops weight_valid the next cycle; values 11..18 are loaded.
  - With WEIGHT_RX_PINGPONG_EN: weight_valid stays 1 and reads return 1..8 until the swap cycle, 11..18 after it.
- Read hold: rd_ce0=0 with a changing rd_address0 -> rd_q0 holds its last value.
